// File: rtl/ct_pkg.sv
// ct_pkg: definitions shared by the ct_* fabric stages.
//   ct_state_e  - arbitration state (CT_IDLE / CT_LOCKED)
//   clog2       - ceiling log2 for elaboration-time width math
//   idx_width   - width of an input index, never narrower than one bit
package ct_pkg;

  typedef enum logic {
    CT_IDLE   = 1'b0,
    CT_LOCKED = 1'b1
  } ct_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/ct_rr_arbiter.sv
// ct_rr_arbiter: combinational round-robin pick over NI requesters.
//   req     - request per input
//   ptr     - highest-priority input index (scan starts here and wraps)
//   gnt     - one-hot grant, all zero when nothing requests
//   gnt_idx - binary index of the granted input (0 when nothing requests)
module ct_rr_arbiter
  import ct_pkg::*;
#(
  parameter  int NI = 2,
  localparam int WI = idx_width(NI)
) (
  input  logic [NI-1:0] req,
  input  logic [WI-1:0] ptr,
  output logic [NI-1:0] gnt,
  output logic [WI-1:0] gnt_idx
);

  generate
    if (NI == 1) begin : g_one
      logic unused_ptr;
      assign unused_ptr = ^ptr;
      assign gnt        = req;
      assign gnt_idx    = '0;
    end else begin : g_many
      logic [WI-1:0] idx;
      logic          found;

      // Walk ptr, ptr+1, ..., NI-1, 0, ... once; the first requester wins.
      // The wrap is an explicit compare so non-power-of-2 NI works.
      always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = (int'(ptr) < NI) ? ptr : '0;
        for (int i = 0; i < NI; i++) begin
          if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
          end
          idx = (idx == WI'(NI - 1)) ? '0 : idx + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ct_merge.sv
// ct_merge: packet-aware NI-to-1 merge with round-robin arbitration.
// A granted input keeps the output until its end-of-packet beat has
// transferred, so packets from different sources never interleave.
//   clk, reset (async, active low)
//   i_data/i_valid/o_ready - NI input streams, input k at [k*WO +: WO]
//   o_data/o_valid/i_ready - registered output stream
//   dbg_state              - current arbitration state
//
// Handshake: a word moves on input k when i_valid[k] & o_ready[k] and on
// the output when o_valid & i_ready. Senders never withdraw valid or data
// once presented. o_ready depends on i_valid, state, o_valid and i_ready
// only; i_data reaches control logic solely through its eop bit.
module ct_merge
  import ct_pkg::*;
#(
  parameter int NI      = 2,
  parameter int WO      = 8,
  parameter int EOP_LOC = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NI*WO-1:0] i_data,
  input  logic [NI-1:0]    i_valid,
  output logic [NI-1:0]    o_ready,
  output logic [WO-1:0]    o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output ct_state_e        dbg_state
);

  localparam int WI = idx_width(NI);

  ct_state_e     state_q, state_d;
  logic [WI-1:0] own_q, own_d;
  logic [WI-1:0] rr_q, rr_d;
  logic          free;
  logic [NI-1:0] gnt;
  logic [WI-1:0] gnt_idx;
  logic [WI-1:0] sel_idx;
  logic [WO-1:0] sel_data;
  logic          sel_eop;
  logic          xfer;

  function automatic logic [WI-1:0] wrap_inc(input logic [WI-1:0] k);
    return (k == WI'(NI - 1)) ? '0 : k + 1'b1;
  endfunction

  // Output slot can take a word when empty or draining this cycle.
  assign free = ~o_valid | i_ready;

  ct_rr_arbiter #(.NI(NI)) u_arb (
    .req    (i_valid),
    .ptr    (rr_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  // Input currently offered the slot: the owner while locked, else the
  // round-robin candidate.
  assign sel_idx = (state_q == CT_LOCKED) ? own_q : gnt_idx;

  generate
    if (NI == 1) begin : g_single
      assign sel_data = i_data;
    end else begin : g_multi
      logic [WO-1:0] word [NI];
      for (genvar k = 0; k < NI; k++) begin : g_word
        assign word[k] = i_data[k*WO +: WO];
      end
      assign sel_data = word[sel_idx];
    end
  endgenerate

  assign sel_eop = sel_data[EOP_LOC];
  assign xfer    = |(i_valid & o_ready);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CT_IDLE;
      own_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    rr_d    = rr_q;
    if (xfer) begin
      case (state_q)
        CT_IDLE: begin
          if (sel_eop) begin
            rr_d = wrap_inc(sel_idx);
          end else begin
            state_d = CT_LOCKED;
            own_d   = sel_idx;
          end
        end
        CT_LOCKED: begin
          if (sel_eop) begin
            state_d = CT_IDLE;
            rr_d    = wrap_inc(own_q);
          end
        end
      endcase
    end
  end

  // Output logic. With a single input there is nothing to arbitrate, so
  // the only input always sees the slot state (own_q is 0 there).
  always_comb begin
    o_ready   = '0;
    dbg_state = state_q;
    if (reset) begin
      if (NI == 1 || state_q == CT_LOCKED) begin
        o_ready = NI'(free) << own_q;
      end else begin
        o_ready = gnt & {NI{free}};
      end
    end
  end

  // Output slot: loaded only by a completed input transfer, otherwise it
  // empties when drained and holds its data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_data  <= sel_data;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
